// File: rtl/vending_core_param.sv
// rtl/vending_core_param.sv - parametrised vending engine: credit, N-product select, multi-cup order, greedy change
// All money is in 50-won units; one FSM owns credit, order latching and change payout.
module vending_core_param #(
    parameter int N_PROD  = 4,
    parameter int CW      = 10,
    parameter int MAX_QTY = 5
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [3:0]                Coin,
    input  logic [N_PROD-1:0]         Sel,
    input  logic [2:0]                Qty,
    input  logic                      Confirm,
    input  logic                      Return,
    input  logic                      Done,
    input  logic                      TakeOut,
    input  logic [N_PROD*CW-1:0]      Price,
    output logic [CW-1:0]             Sum,
    output logic [$clog2(N_PROD)-1:0] Kind,
    output logic [2:0]                Cups,
    output logic                      Making,
    output logic                      Coffee,
    output logic [3:0]                Ret,
    output logic                      Reject,
    output logic                      Err,
    output logic                      Busy
);

    localparam int KW = $clog2(N_PROD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CREDIT,
        S_MAKE,
        S_SERVE,
        S_CHANGE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_sum, w_sum_nxt;
    logic [KW-1:0]   r_kind, w_kind_nxt;
    logic [2:0]      r_cups, w_cups_nxt;
    logic            r_valid, w_valid_nxt;
    logic [3:0]      r_ret, w_ret_nxt;
    logic            r_reject, w_reject_nxt;
    logic            r_err, w_err_nxt;

    logic [4:0]      w_coin_val;
    logic            w_coin_single;
    logic [CW:0]     w_sum_plus;
    logic            w_coin_ok;
    logic [CW-1:0]   w_coin_add;
    logic [KW-1:0]   w_sel_idx;
    logic            w_sel_ok;
    logic [CW-1:0]   w_price;
    logic [CW+2:0]   w_cost;
    logic            w_accept;
    logic [3:0]      w_chg_coin;
    logic [CW-1:0]   w_chg_val;

    always_comb begin
        case (Coin)
            4'b0001: w_coin_val = 5'd1;
            4'b0010: w_coin_val = 5'd2;
            4'b0100: w_coin_val = 5'd10;
            4'b1000: w_coin_val = 5'd20;
            default: w_coin_val = 5'd0;
        endcase
    end

    assign w_coin_single = $onehot(Coin);
    assign w_sum_plus    = {1'b0, r_sum} + (CW+1)'(w_coin_val);
    assign w_coin_ok     = w_coin_single && !w_sum_plus[CW] &&
                           (r_state == S_IDLE || r_state == S_CREDIT);
    assign w_coin_add    = w_coin_ok ? CW'(w_coin_val) : '0;

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (Sel[i]) w_sel_idx = KW'(i);
        end
    end
    assign w_sel_ok = $onehot(Sel);

    always_comb begin
        w_price = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (r_kind == KW'(i)) w_price = Price[i*CW +: CW];
        end
    end

    // Full-width product so a large price times cups can never wrap into a false accept
    assign w_cost   = (CW+3)'(w_price) * (CW+3)'(Qty);
    assign w_accept = r_valid && (Qty != 3'd0) && (Qty <= 3'(MAX_QTY)) &&
                      ({3'b000, r_sum} >= w_cost);

    always_comb begin
        if (r_sum >= CW'(20)) begin
            w_chg_coin = 4'b1000;
            w_chg_val  = CW'(20);
        end else if (r_sum >= CW'(10)) begin
            w_chg_coin = 4'b0100;
            w_chg_val  = CW'(10);
        end else if (r_sum >= CW'(2)) begin
            w_chg_coin = 4'b0010;
            w_chg_val  = CW'(2);
        end else begin
            w_chg_coin = 4'b0001;
            w_chg_val  = CW'(1);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sum_nxt    = r_sum;
        w_kind_nxt   = r_kind;
        w_cups_nxt   = r_cups;
        w_valid_nxt  = r_valid;
        w_ret_nxt    = 4'b0000;
        w_reject_nxt = (Coin != 4'b0000) && !w_coin_ok;
        w_err_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sel_ok) w_kind_nxt = w_sel_idx;
                if (w_coin_ok) begin
                    w_sum_nxt   = w_sum_plus[CW-1:0];
                    w_state_nxt = S_CREDIT;
                end
            end
            S_CREDIT: begin
                if (w_sel_ok) begin
                    w_kind_nxt  = w_sel_idx;
                    w_valid_nxt = 1'b1;
                end
                // Confirm outranks Return; a same-cycle coin lands after the deduction
                if (Confirm) begin
                    if (w_accept) begin
                        w_sum_nxt   = r_sum - w_cost[CW-1:0] + w_coin_add;
                        w_cups_nxt  = Qty;
                        w_state_nxt = S_MAKE;
                    end else begin
                        w_err_nxt = 1'b1;
                        w_sum_nxt = r_sum + w_coin_add;
                    end
                end else if (Return) begin
                    w_sum_nxt   = r_sum + w_coin_add;
                    w_state_nxt = S_CHANGE;
                end else begin
                    w_sum_nxt = r_sum + w_coin_add;
                end
            end
            S_MAKE: begin
                if (Done) w_state_nxt = S_SERVE;
            end
            S_SERVE: begin
                if (TakeOut) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = (r_sum == '0) ? S_IDLE : S_CREDIT;
                end
            end
            S_CHANGE: begin
                if (r_sum == '0) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ret_nxt = w_chg_coin;
                    w_sum_nxt = r_sum - w_chg_val;
                    if (r_sum == w_chg_val) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_sum    <= '0;
            r_kind   <= '0;
            r_cups   <= 3'd0;
            r_valid  <= 1'b0;
            r_ret    <= 4'b0000;
            r_reject <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sum    <= w_sum_nxt;
            r_kind   <= w_kind_nxt;
            r_cups   <= w_cups_nxt;
            r_valid  <= w_valid_nxt;
            r_ret    <= w_ret_nxt;
            r_reject <= w_reject_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign Sum    = r_sum;
    assign Kind   = r_kind;
    assign Cups   = r_cups;
    assign Making = (r_state == S_MAKE);
    assign Coffee = (r_state == S_SERVE);
    assign Ret    = r_ret;
    assign Reject = r_reject;
    assign Err    = r_err;
    assign Busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_vending_core_param.sv
// tb/tb_vending_core_param.sv - vector table, corner sequences and randomized model check for vending_core_param
module tb_vending_core_param;

    localparam int N_PROD  = 4;
    localparam int CW      = 10;
    localparam int MAX_QTY = 5;
    localparam int SUM_MAX = (1 << CW) - 1;

    logic                 CLK = 1'b0;
    logic                 RST_N;
    logic [3:0]           coin;
    logic [N_PROD-1:0]    sel;
    logic [2:0]           qty;
    logic                 confirm, ret_req, done, takeout;
    logic [N_PROD*CW-1:0] price;
    logic [CW-1:0]        sum;
    logic [1:0]           kind;
    logic [2:0]           cups;
    logic                 making, coffee, reject, err, busy;
    logic [3:0]           ret;

    int tests = 0;
    int fails = 0;
    int price_tab[N_PROD] = '{30, 12, 7, 3};
    int denom[4] = '{1, 2, 10, 20};

    vending_core_param #(.N_PROD(N_PROD), .CW(CW), .MAX_QTY(MAX_QTY)) dut (
        .CLK(CLK), .RST_N(RST_N), .Coin(coin), .Sel(sel), .Qty(qty),
        .Confirm(confirm), .Return(ret_req), .Done(done), .TakeOut(takeout),
        .Price(price), .Sum(sum), .Kind(kind), .Cups(cups), .Making(making),
        .Coffee(coffee), .Ret(ret), .Reject(reject), .Err(err), .Busy(busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [23:0] pk(input int s, input int k, input int cu, input bit mk,
                                       input bit cof, input logic [3:0] r, input bit rj,
                                       input bit er, input bit bz);
        return {10'(s), 2'(k), 3'(cu), mk, cof, r, rj, er, bz};
    endfunction

    task automatic check(input string nm, input logic [23:0] exp);
        logic [23:0] got;
        got = {sum, kind, cups, making, coffee, ret, reject, err, busy};
        tests++;
        if (got !== exp) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s: got sum=%0d kind=%0d cups=%0d mk=%b cof=%b ret=%b rej=%b err=%b busy=%b; expected sum=%0d kind=%0d cups=%0d mk=%b cof=%b ret=%b rej=%b err=%b busy=%b",
                         nm, got[23:14], got[13:12], got[11:9], got[8], got[7], got[6:3], got[2], got[1], got[0],
                         exp[23:14], exp[13:12], exp[11:9], exp[8], exp[7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [3:0] s, input logic [2:0] q,
                         input bit cf, input bit rt, input bit dn, input bit to);
        coin = c; sel = s; qty = q; confirm = cf; ret_req = rt; done = dn; takeout = to;
        @(posedge CLK);
        #1;
        coin = 4'b0; sel = 4'b0; qty = 3'd0; confirm = 1'b0; ret_req = 1'b0; done = 1'b0; takeout = 1'b0;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #2;
        RST_N = 1'b1;
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] c, s;
        logic [2:0] q;
        bit         cf, rt, dn, to;
        int         e_sum;
        logic [3:0] e_ret;
        bit         e_rej, e_err, e_mk, e_cof, e_busy;
        int         e_kind, e_cups;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit rst, input logic [3:0] c, input logic [3:0] s,
                                input logic [2:0] q, input bit cf, input bit rt, input bit dn,
                                input bit to, input int e_sum, input logic [3:0] e_ret,
                                input bit e_rej, input bit e_err, input bit e_mk, input bit e_cof,
                                input bit e_busy, input int e_kind, input int e_cups);
        vec_t v;
        v.rst = rst; v.c = c; v.s = s; v.q = q; v.cf = cf; v.rt = rt; v.dn = dn; v.to = to;
        v.e_sum = e_sum; v.e_ret = e_ret; v.e_rej = e_rej; v.e_err = e_err; v.e_mk = e_mk;
        v.e_cof = e_cof; v.e_busy = e_busy; v.e_kind = e_kind; v.e_cups = e_cups;
        vecs.push_back(v);
    endfunction

    // Reference model: spec rules in plain arithmetic; change is a precomputed coin list
    localparam int M_IDLE = 0, M_CREDIT = 1, M_MAKE = 2, M_SERVE = 3, M_CHANGE = 4;
    int         m_mode, m_sum, m_kind, m_cups;
    bit         m_valid, m_rej, m_err;
    logic [3:0] m_ret;
    int         m_q[$];

    function automatic void model_reset();
        m_mode = M_IDLE; m_sum = 0; m_kind = 0; m_cups = 0; m_valid = 0;
        m_rej = 0; m_err = 0; m_ret = 4'b0; m_q.delete();
    endfunction

    function automatic void model_step(input logic [3:0] c, input logic [3:0] s, input int q,
                                       input bit cf, input bit rt, input bit dn, input bit to);
        int  cv = 0, add_v, sidx = 0, cost, rem, idx;
        bit  c_ok, old_valid;
        int  old_kind;
        for (int i = 0; i < 4; i++) if (c[i]) cv = denom[i];
        for (int i = 0; i < N_PROD; i++) if (s[i]) sidx = i;
        c_ok  = (m_mode == M_IDLE || m_mode == M_CREDIT) && ($countones(c) == 1) && (m_sum + cv <= SUM_MAX);
        m_rej = (c != 4'b0) && !c_ok;
        add_v = c_ok ? cv : 0;
        m_err = 0;
        m_ret = 4'b0;
        old_valid = m_valid;
        old_kind  = m_kind;
        case (m_mode)
            M_IDLE: begin
                if ($countones(s) == 1) m_kind = sidx;
                if (c_ok) begin m_sum += add_v; m_mode = M_CREDIT; end
            end
            M_CREDIT: begin
                if ($countones(s) == 1) begin m_kind = sidx; m_valid = 1; end
                if (cf) begin
                    cost = price_tab[old_kind] * q;
                    if (old_valid && q >= 1 && q <= MAX_QTY && m_sum >= cost) begin
                        m_sum = m_sum - cost + add_v; m_cups = q; m_mode = M_MAKE;
                    end else begin
                        m_err = 1; m_sum += add_v;
                    end
                end else if (rt) begin
                    m_sum += add_v;
                    rem = m_sum;
                    for (int i = 3; i >= 0; i--) begin
                        repeat (rem / denom[i]) m_q.push_back(i);
                        rem = rem % denom[i];
                    end
                    m_mode = M_CHANGE;
                end else begin
                    m_sum += add_v;
                end
            end
            M_MAKE:  if (dn) m_mode = M_SERVE;
            M_SERVE: if (to) begin m_valid = 0; m_mode = (m_sum == 0) ? M_IDLE : M_CREDIT; end
            default: begin
                if (m_q.size() != 0) begin
                    idx = m_q.pop_front();
                    m_ret[idx] = 1'b1;
                    m_sum -= denom[idx];
                end
                if (m_q.size() == 0) begin m_valid = 0; m_mode = M_IDLE; end
            end
        endcase
    endfunction

    initial begin
        for (int i = 0; i < N_PROD; i++) price[i*CW +: CW] = CW'(price_tab[i]);
        coin = 4'b0; sel = 4'b0; qty = 3'd0; confirm = 0; ret_req = 0; done = 0; takeout = 0;
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset", pk(0, 0, 0, 0, 0, 4'b0, 0, 0, 0));
        RST_N = 1'b1;

        // greedy change of 37, then Confirm/Return ignored in IDLE
        add(1, 4'b1000, 0, 0, 0, 0, 0, 0, 20, 4'b0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0100, 0, 0, 0, 0, 0, 0, 30, 4'b0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0010, 0, 0, 0, 0, 0, 0, 32, 4'b0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0010, 0, 0, 0, 0, 0, 0, 34, 4'b0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0010, 0, 0, 0, 0, 0, 0, 36, 4'b0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0001, 0, 0, 0, 0, 0, 0, 37, 4'b0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 1, 0, 0, 37, 4'b0000, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 17, 4'b1000, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 0, 0,  7, 4'b0100, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 0, 0,  5, 4'b0010, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 0, 0,  3, 4'b0010, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 0, 0,  1, 4'b0010, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 0, 0,  0, 4'b0001, 0, 0, 0, 0, 0, 0, 0);
        add(0, 4'b0000, 0, 1, 1, 1, 0, 0,  0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        // single-cup order through MAKE/SERVE back to CREDIT
        add(0, 4'b1000, 0, 0, 0, 0, 0, 0, 20, 4'b0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0100, 0, 0, 0, 0, 0, 0, 30, 4'b0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0100, 0, 0, 0, 0, 0, 0, 40, 4'b0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0000, 4'b0001, 0, 0, 0, 0, 0, 40, 4'b0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 1, 1, 0, 0, 0, 10, 4'b0, 0, 0, 1, 0, 1, 0, 1);
        add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 10, 4'b0, 0, 0, 1, 0, 1, 0, 1);
        add(0, 4'b0000, 0, 0, 0, 0, 1, 0, 10, 4'b0, 0, 0, 0, 1, 1, 0, 1);
        add(0, 4'b0000, 0, 0, 0, 0, 0, 1, 10, 4'b0, 0, 0, 0, 0, 1, 0, 1);
        // refused orders: short credit, zero cups, then product_valid cleared after serve
        add(0, 4'b0100, 0, 0, 0, 0, 0, 0, 20, 4'b0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 4'b0000, 4'b0010, 0, 0, 0, 0, 0, 20, 4'b0, 0, 0, 0, 0, 1, 1, 1);
        add(0, 4'b0000, 0, 2, 1, 0, 0, 0, 20, 4'b0, 0, 1, 0, 0, 1, 1, 1);
        add(0, 4'b0000, 0, 0, 1, 0, 0, 0, 20, 4'b0, 0, 1, 0, 0, 1, 1, 1);
        add(0, 4'b0000, 0, 1, 1, 0, 0, 0,  8, 4'b0, 0, 0, 1, 0, 1, 1, 1);
        add(0, 4'b0000, 0, 0, 0, 0, 1, 0,  8, 4'b0, 0, 0, 0, 1, 1, 1, 1);
        add(0, 4'b0000, 0, 0, 0, 0, 0, 1,  8, 4'b0, 0, 0, 0, 0, 1, 1, 1);
        add(0, 4'b0000, 0, 1, 1, 0, 0, 0,  8, 4'b0, 0, 1, 0, 0, 1, 1, 1);
        // coin with Return, Confirm with Return, coin with Confirm, coin in MAKE
        add(1, 4'b0010, 0, 0, 0, 0, 0, 0,  2, 4'b0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0100, 0, 0, 0, 1, 0, 0, 12, 4'b0000, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 0, 0,  2, 4'b0100, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 0, 0,  0, 4'b0010, 0, 0, 0, 0, 0, 0, 0);
        add(0, 4'b1000, 0, 0, 0, 0, 0, 0, 20, 4'b0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 4'b0000, 4'b0010, 0, 0, 0, 0, 0, 20, 4'b0, 0, 0, 0, 0, 1, 1, 0);
        add(0, 4'b0000, 0, 2, 1, 1, 0, 0, 20, 4'b0, 0, 1, 0, 0, 1, 1, 0);
        add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 20, 4'b0, 0, 0, 0, 0, 1, 1, 0);
        add(0, 4'b0001, 0, 1, 1, 1, 0, 0,  9, 4'b0, 0, 0, 1, 0, 1, 1, 1);
        add(0, 4'b0100, 0, 0, 0, 0, 0, 0,  9, 4'b0, 1, 0, 1, 0, 1, 1, 1);
        add(0, 4'b0000, 0, 0, 0, 0, 1, 0,  9, 4'b0, 0, 0, 0, 1, 1, 1, 1);
        add(0, 4'b0000, 0, 0, 0, 0, 1, 1,  9, 4'b0, 0, 0, 0, 0, 1, 1, 1);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i].c, vecs[i].s, vecs[i].q, vecs[i].cf, vecs[i].rt, vecs[i].dn, vecs[i].to);
            check($sformatf("vec%0d", i),
                  pk(vecs[i].e_sum, vecs[i].e_kind, vecs[i].e_cups, vecs[i].e_mk, vecs[i].e_cof,
                     vecs[i].e_ret, vecs[i].e_rej, vecs[i].e_err, vecs[i].e_busy));
        end

        // credit ceiling at 2^CW-1, malformed coin, oversize order, coin during MAKE
        do_reset();
        repeat (50) drive(4'b1000, 0, 0, 0, 0, 0, 0);
        drive(4'b0100, 0, 0, 0, 0, 0, 0);
        check("sum_1010", pk(1010, 0, 0, 0, 0, 4'b0, 0, 0, 1));
        drive(4'b1000, 0, 0, 0, 0, 0, 0);
        check("ovf_reject", pk(1010, 0, 0, 0, 0, 4'b0, 1, 0, 1));
        drive(4'b0011, 0, 0, 0, 0, 0, 0);
        check("multi_coin_reject", pk(1010, 0, 0, 0, 0, 4'b0, 1, 0, 1));
        drive(4'b0100, 0, 0, 0, 0, 0, 0);
        drive(4'b0010, 0, 0, 0, 0, 0, 0);
        drive(4'b0001, 0, 0, 0, 0, 0, 0);
        check("sum_max", pk(1023, 0, 0, 0, 0, 4'b0, 0, 0, 1));
        drive(4'b0001, 0, 0, 0, 0, 0, 0);
        check("max_plus_one_reject", pk(1023, 0, 0, 0, 0, 4'b0, 1, 0, 1));
        drive(4'b0000, 4'b1000, 0, 0, 0, 0, 0);
        drive(4'b0000, 0, 3'd7, 1, 0, 0, 0);
        check("qty_over_max_err", pk(1023, 3, 0, 0, 0, 4'b0, 0, 1, 1));
        drive(4'b0000, 0, 3'd5, 1, 0, 0, 0);
        check("qty_max_accept", pk(1008, 3, 5, 1, 0, 4'b0, 0, 0, 1));
        drive(4'b0100, 0, 0, 0, 0, 0, 0);
        check("coin_in_make_reject", pk(1008, 3, 5, 1, 0, 4'b0, 1, 0, 1));

        // asynchronous reset in CHANGE pays nothing out
        do_reset();
        repeat (4) drive(4'b0010, 0, 0, 0, 0, 0, 0);
        drive(4'b0001, 0, 0, 0, 0, 0, 0);
        drive(4'b0000, 0, 0, 0, 1, 0, 0);
        check("change_entry", pk(9, 0, 0, 0, 0, 4'b0, 0, 0, 1));
        #2 RST_N = 1'b0;
        #1;
        check("async_reset", pk(0, 0, 0, 0, 0, 4'b0, 0, 0, 0));
        #2 RST_N = 1'b1;
        drive(4'b0000, 0, 0, 0, 0, 0, 0);
        check("after_reset_idle", pk(0, 0, 0, 0, 0, 4'b0, 0, 0, 0));

        // randomized run against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            logic [3:0] rc, rs;
            logic [2:0] rq;
            bit rcf, rrt, rdn, rto;
            int r;
            r  = $urandom_range(0, 9);
            rc = (r < 6) ? 4'b0 : (r < 9) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            r  = $urandom_range(0, 99);
            rs = (r < 82) ? 4'b0 : (r < 97) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            rq  = 3'($urandom_range(0, 7));
            rcf = ($urandom_range(0, 99) < 15);
            rrt = ($urandom_range(0, 99) < 6);
            rdn = ($urandom_range(0, 99) < 30);
            rto = ($urandom_range(0, 99) < 30);
            model_step(rc, rs, int'(rq), rcf, rrt, rdn, rto);
            drive(rc, rs, rq, rcf, rrt, rdn, rto);
            check($sformatf("rand%0d", n),
                  pk(m_sum, m_kind, m_cups, m_mode == M_MAKE, m_mode == M_SERVE, m_ret,
                     m_rej, m_err, m_mode != M_IDLE));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
